// File: rtl/trace_issue_unit_if.sv
// Trace record channel between the trace loader and the issue unit.
// Loader drives the record; the issue unit answers with in_ready.
interface trace_issue_unit_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_op;
   logic [47:0] in_addr;
   logic        in_last;

   modport master (
      output in_valid,
      output in_op,
      output in_addr,
      output in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_op,
      input  in_addr,
      input  in_last,
      output in_ready
   );
endinterface

// File: rtl/trace_issue_unit.sv
// Trace issue unit: buffers trace records, filters ops and issues
// one access at a time to the cache engine with a programmable gap.
module trace_issue_unit #(
   parameter int DEPTH     = 8,
   parameter int ISSUE_GAP = 3,
   parameter int CNT_W     = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   trace_issue_unit_if.slave      rec,
   output logic                   issue_valid,
   output logic [47:0]            cache_addr,
   output logic [7:0]             cache_op,
   output logic                   cache_lvl,
   output logic                   busy,
   output logic                   done,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [CNT_W-1:0]       issued_cnt,
   output logic [CNT_W-1:0]       reads_cnt,
   output logic [CNT_W-1:0]       writes_cnt,
   output logic [CNT_W-1:0]       dropped_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP + 1) : 1;
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
   localparam logic [7:0] OP_R = 8'h52;
   localparam logic [7:0] OP_W = 8'h57;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      GAP,
      DONE
   } state_t;

   state_t state;
   state_t state_nx;

   logic [47:0]   mem_addr [DEPTH];
   logic          mem_wr   [DEPTH];
   logic          mem_last [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [GW-1:0] gap_cnt;
   logic          last_seen;

   logic op_rd;
   logic op_wr;
   logic push;
   logic store;
   logic drop;
   logic empty;
   logic pop;
   logic restart;
   logic head_last;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   assign op_rd = (rec.in_op == 8'h52) || (rec.in_op == 8'h72);
   assign op_wr = (rec.in_op == 8'h57) || (rec.in_op == 8'h77);

   assign rec.in_ready = (fifo_count < FULL);
   assign push         = rec.in_valid & rec.in_ready;
   assign store        = push & (op_rd | op_wr);
   assign drop         = push & ~(op_rd | op_wr);

   assign empty     = (fifo_count == '0);
   assign pop       = (state == RUN) && !empty;
   assign restart   = start && ((state == IDLE) || (state == DONE));
   assign head_last = mem_last[rd_ptr];

   assign cache_lvl = 1'b0;

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // FSM next-state decode
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (start) state_nx = RUN;
         end
         RUN: begin
            if (pop) begin
               if (head_last) state_nx = DONE;
               else if (ISSUE_GAP > 0) state_nx = GAP;
            end else if (last_seen) begin
               state_nx = DONE;
            end
         end
         GAP: begin
            if (gap_cnt == GW'(1)) state_nx = RUN;
         end
         DONE: begin
            if (start) state_nx = RUN;
         end
      endcase
   end

   // FSM status outputs
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state)
         RUN:     busy = 1'b1;
         GAP:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Gap countdown loaded on each non-final issue
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gap_cnt <= '0;
      end else if (pop && !head_last) begin
         gap_cnt <= GW'(ISSUE_GAP);
      end else if (state == GAP) begin
         gap_cnt <= gap_cnt - GW'(1);
      end
   end

   // FIFO storage; contents need no reset, occupancy guards reads
   always_ff @(posedge clk) begin
      if (store) begin
         mem_addr[wr_ptr] <= rec.in_addr;
         mem_wr[wr_ptr]   <= op_wr;
         mem_last[wr_ptr] <= rec.in_last;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (store) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         unique case ({store, pop})
            2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
            2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // A dropped record carrying the last marker still ends the run
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_seen <= 1'b0;
      end else begin
         last_seen <= ((restart && state == DONE) ? 1'b0 : last_seen)
                    | (drop & rec.in_last);
      end
   end

   // Issue register: holds the last access between strobes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         issue_valid <= 1'b0;
         cache_addr  <= '0;
         cache_op    <= '0;
      end else begin
         issue_valid <= pop;
         if (pop) begin
            cache_addr <= mem_addr[rd_ptr];
            cache_op   <= mem_wr[rd_ptr] ? OP_W : OP_R;
         end
      end
   end

   // Saturating statistics, cleared when a run begins
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         issued_cnt  <= '0;
         reads_cnt   <= '0;
         writes_cnt  <= '0;
         dropped_cnt <= '0;
      end else if (restart) begin
         issued_cnt  <= '0;
         reads_cnt   <= '0;
         writes_cnt  <= '0;
         dropped_cnt <= '0;
      end else begin
         if (pop) begin
            issued_cnt <= sat_inc(issued_cnt);
            if (mem_wr[rd_ptr]) writes_cnt <= sat_inc(writes_cnt);
            else                reads_cnt  <= sat_inc(reads_cnt);
         end
         if (drop) dropped_cnt <= sat_inc(dropped_cnt);
      end
   end

endmodule

// File: tb/tb_trace_issue_unit.sv
// Testbench for trace_issue_unit: scoreboard of expected issues
// plus directed checks on timing, back-pressure, reset and saturation.
module tb_trace_issue_unit;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic start0 = 1'b0;

   always #5 clk = ~clk;

   trace_issue_unit_if ifc();
   trace_issue_unit_if ifc0();

   logic        iv, clvl, bsy, dn;
   logic [47:0] caddr;
   logic [7:0]  cop;
   logic [3:0]  fc;
   logic [15:0] iss, rds, wrs, drp;

   logic        iv0, clvl0, bsy0, dn0;
   logic [47:0] caddr0;
   logic [7:0]  cop0;
   logic [3:0]  fc0;
   logic [3:0]  iss0, rds0, wrs0, drp0;

   trace_issue_unit #(.DEPTH(8), .ISSUE_GAP(3), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .rec(ifc),
      .issue_valid(iv), .cache_addr(caddr), .cache_op(cop),
      .cache_lvl(clvl), .busy(bsy), .done(dn), .fifo_count(fc),
      .issued_cnt(iss), .reads_cnt(rds), .writes_cnt(wrs),
      .dropped_cnt(drp)
   );

   trace_issue_unit #(.DEPTH(8), .ISSUE_GAP(0), .CNT_W(4)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .rec(ifc0),
      .issue_valid(iv0), .cache_addr(caddr0), .cache_op(cop0),
      .cache_lvl(clvl0), .busy(bsy0), .done(dn0), .fifo_count(fc0),
      .issued_cnt(iss0), .reads_cnt(rds0), .writes_cnt(wrs0),
      .dropped_cnt(drp0)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   logic [55:0] exp_q[$];
   int          strobe_q[$];
   logic [15:0] iss_m, rd_m, wr_m, drop_m;
   int          push_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   task automatic fail_to(input string name);
      n_chk++;
      $display("FAIL %s: timed out", name);
   endtask

   function automatic logic [15:0] sinc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic void clear_model();
      iss_m = 0;
      rd_m = 0;
      wr_m = 0;
      drop_m = 0;
   endfunction

   // reference: normalise op, queue accepted accesses, count drops
   function automatic void model_push(input logic [7:0] op,
                                      input logic [47:0] a);
      if (op == "R" || op == "r") exp_q.push_back({8'h52, a});
      else if (op == "W" || op == "w") exp_q.push_back({8'h57, a});
      else drop_m = sinc(drop_m);
   endfunction

   // monitor: every strobe must match the oldest expected access
   always @(posedge clk) begin
      #1;
      if (iv === 1'b1) begin
         strobe_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            chk("strobe_unexpected", {16'd0, caddr}, 64'hDEAD);
         end else begin
            logic [55:0] e;
            e = exp_q.pop_front();
            chk("issue_op", {56'd0, cop}, {56'd0, e[55:48]});
            chk("issue_addr", {16'd0, caddr}, {16'd0, e[47:0]});
            iss_m = sinc(iss_m);
            if (e[55:48] == 8'h57) wr_m = sinc(wr_m);
            else rd_m = sinc(rd_m);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] op, input logic [47:0] a,
                       input logic l);
      int n = 0;
      ifc.in_valid = 1'b1;
      ifc.in_op = op;
      ifc.in_addr = a;
      ifc.in_last = l;
      while (ifc.in_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) fail_to("push_ready");
      else model_push(op, a);
      tick();
      push_cyc = cyc;
      ifc.in_valid = 1'b0;
   endtask

   task automatic push0(input logic [7:0] op, input logic [47:0] a,
                        input logic l);
      int n = 0;
      ifc0.in_valid = 1'b1;
      ifc0.in_op = op;
      ifc0.in_addr = a;
      ifc0.in_last = l;
      while (ifc0.in_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) fail_to("push0_ready");
      tick();
      ifc0.in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      clear_model();
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (dn !== 1'b1 && n < 3000) begin
         tick();
         n++;
      end
      if (n >= 3000) fail_to(name);
   endtask

   initial begin
      logic [7:0]  ops[7];
      logic [47:0] a0[4];
      logic [63:0] r;
      int          p1;
      int          nrec;
      int          n;

      ops = '{8'h52, 8'h72, 8'h57, 8'h77, 8'h58, 8'h61, 8'h00};
      ifc.in_valid = 0;
      ifc.in_op = 0;
      ifc.in_addr = 0;
      ifc.in_last = 0;
      ifc0.in_valid = 0;
      ifc0.in_op = 0;
      ifc0.in_addr = 0;
      ifc0.in_last = 0;
      clear_model();

      // reset values
      #2;
      chk("rst_issue_valid", {63'd0, iv}, 64'd0);
      chk("rst_busy", {63'd0, bsy}, 64'd0);
      chk("rst_done", {63'd0, dn}, 64'd0);
      chk("rst_fifo_count", {60'd0, fc}, 64'd0);
      chk("rst_in_ready", {63'd0, ifc.in_ready}, 64'd1);
      chk("rst_cache_addr", {16'd0, caddr}, 64'd0);
      chk("rst_cache_op", {56'd0, cop}, 64'd0);
      chk("rst_cache_lvl", {63'd0, clvl}, 64'd0);
      chk("rst_issued", {48'd0, iss}, 64'd0);
      #10;
      reset = 1'b1;
      tick();

      // two records, gap of 3
      pulse_start();
      strobe_q.delete();
      push("R", 48'h000000001000, 1'b0);
      p1 = push_cyc;
      push("W", 48'h00000000203C, 1'b1);
      wait_done("t1_done");
      chk("t1_strobes", strobe_q.size(), 2);
      chk("t1_latency", strobe_q[0] - p1, 1);
      chk("t1_spacing", strobe_q[1] - strobe_q[0], 4);
      chk("t1_busy", {63'd0, bsy}, 64'd0);
      chk("t1_issued", {48'd0, iss}, {48'd0, iss_m});
      chk("t1_reads", {48'd0, rds}, 64'd1);
      chk("t1_writes", {48'd0, wrs}, 64'd1);
      chk("t1_hold_addr", {16'd0, caddr}, 64'h203C);
      chk("t1_hold_op", {56'd0, cop}, 64'h57);

      // lower case ops and a dropped op
      pulse_start();
      push("r", 48'h000000003000, 1'b0);
      push("X", 48'h000000004444, 1'b0);
      push("w", 48'h000000005000, 1'b1);
      wait_done("t2_done");
      chk("t2_dropped", {48'd0, drp}, {48'd0, drop_m});
      chk("t2_issued", {48'd0, iss}, 64'd2);
      chk("t2_reads", {48'd0, rds}, {48'd0, rd_m});

      // fill the FIFO while stopped, ninth record stalls
      for (int i = 0; i < 8; i++)
         push((i % 2) ? "W" : "R", 48'h10000 + 48'(i * 64), 1'b0);
      ifc.in_valid = 1'b1;
      ifc.in_op = "W";
      ifc.in_addr = 48'h0000ABCD0000;
      ifc.in_last = 1'b1;
      chk("t3_full_ready", {63'd0, ifc.in_ready}, 64'd0);
      chk("t3_full_count", {60'd0, fc}, 64'd8);
      pulse_start();
      chk("t3_ready_at_start", {63'd0, ifc.in_ready}, 64'd0);
      tick();
      chk("t3_ready_after_pop", {63'd0, ifc.in_ready}, 64'd1);
      model_push("W", 48'h0000ABCD0000);
      tick();
      ifc.in_valid = 1'b0;
      wait_done("t3_done");
      chk("t3_issued", {48'd0, iss}, 64'd9);
      chk("t3_empty", {60'd0, fc}, 64'd0);

      // back-to-back issue on the zero-gap instance
      a0 = '{48'h100, 48'h200, 48'h300, 48'h400};
      for (int i = 0; i < 4; i++)
         push0((i % 2) ? "R" : "W", a0[i], i == 3);
      chk("t4_preload", {60'd0, fc0}, 64'd4);
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("t4_strobe", {63'd0, iv0}, 64'd1);
         chk("t4_addr", {16'd0, caddr0}, {16'd0, a0[k-1]});
         chk("t4_op", {56'd0, cop0}, (k % 2) ? 64'h57 : 64'h52);
         chk("t4_count", {60'd0, fc0}, 64'(4 - k));
      end
      tick();
      chk("t4_idle", {63'd0, iv0}, 64'd0);
      chk("t4_done", {63'd0, dn0}, 64'd1);

      // counters saturate (4-bit instance)
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int i = 0; i < 20; i++) push0("r", 48'(i), i == 19);
      n = 0;
      while (dn0 !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) fail_to("t6_done");
      chk("t6_reads_sat", {60'd0, rds0}, 64'hF);
      chk("t6_issued_sat", {60'd0, iss0}, 64'hF);
      chk("t6_writes", {60'd0, wrs0}, 64'd0);

      // random traffic against the reference queue
      pulse_start();
      nrec = 30;
      for (int i = 0; i < nrec; i++) begin
         n = $urandom_range(0, 3);
         repeat (n) tick();
         r = {$urandom, $urandom};
         push(ops[$urandom_range(0, 6)], r[47:0], i == nrec - 1);
      end
      wait_done("rnd_done");
      chk("rnd_issued", {48'd0, iss}, {48'd0, iss_m});
      chk("rnd_reads", {48'd0, rds}, {48'd0, rd_m});
      chk("rnd_writes", {48'd0, wrs}, {48'd0, wr_m});
      chk("rnd_dropped", {48'd0, drp}, {48'd0, drop_m});
      chk("rnd_drained", exp_q.size(), 0);

      // reset in the middle of a gap with entries queued
      pulse_start();
      for (int i = 0; i < 4; i++) push("R", 48'h7000 + 48'(i), 1'b0);
      chk("t5_in_gap_count", {60'd0, fc}, 64'd3);
      #2;
      reset = 1'b0;
      #1;
      exp_q.delete();
      clear_model();
      chk("t5_rst_count", {60'd0, fc}, 64'd0);
      chk("t5_rst_busy", {63'd0, bsy}, 64'd0);
      chk("t5_rst_addr", {16'd0, caddr}, 64'd0);
      chk("t5_rst_issued", {48'd0, iss}, 64'd0);
      chk("t5_rst_ready", {63'd0, ifc.in_ready}, 64'd1);
      #3;
      reset = 1'b1;
      tick();
      pulse_start();
      repeat (10) tick();
      chk("t5_no_issue", {48'd0, iss}, 64'd0);
      chk("t5_waiting", {63'd0, bsy}, 64'd1);
      push("R", 48'h0000000BEEF0, 1'b1);
      wait_done("t5_done");
      chk("t5_issued", {48'd0, iss}, 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
